// File: rtl/jelly3_bram_burst_reader_pkg.sv
// Shared types for the jelly3 BRAM burst reader: FSM state encoding and
// the width of the outstanding-read credit counter.
package jelly3_bram_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  // Credit must hold the full value FIFO_DEPTH, hence depth+1 codes.
  function automatic int credit_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/jelly3_bram_burst_reader_fifo.sv
// Response FIFO for the burst reader: registered head, DATA+ID+LAST payload,
// async active-low reset, push and pop allowed together when full or empty.
module jelly3_bram_burst_reader_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [CNT_BITS-1:0] count;

  logic load;
  logic buf_rd;
  logic buf_wr;

  // The head register refills whenever it is empty or being popped; with an
  // empty buffer an incoming word bypasses straight into the head register.
  always_comb begin
    load   = !m_valid || m_ready;
    buf_rd = load && (count != '0);
    buf_wr = s_valid && !(load && (count == '0));
  end

  always_ff @(posedge clk) begin
    if (buf_wr) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (buf_wr) begin
        wr_ptr <= wr_ptr + PTR_BITS'(1);
      end
      if (buf_rd) begin
        m_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_BITS'(1);
      end else if (load) begin
        m_data <= s_data;
      end
      if (load) begin
        m_valid <= (count != '0) || s_valid;
      end
      case ({buf_wr, buf_rd})
        2'b10:   count <= count + CNT_BITS'(1);
        2'b01:   count <= count - CNT_BITS'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jelly3_bram_burst_reader.sv
// Burst-read initiator for the jelly3 BRAM command/response bus.
// Optional: define JELLY3_BRAM_BURST_READER_CHECK_EN to add the sticky err output.
module jelly3_bram_burst_reader
  import jelly3_bram_burst_reader_pkg::*;
#(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_BITS  = 32,
  parameter int ID_BITS    = 4,
  parameter int LEN_BITS   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,

  input  logic [ADDR_BITS-1:0]   s_addr,
  input  logic [LEN_BITS-1:0]    s_len,
  input  logic [ID_BITS-1:0]     s_id,
  input  logic                   s_valid,
  output logic                   s_ready,

  output logic [ID_BITS-1:0]     m_cid,
  output logic [ADDR_BITS-1:0]   m_caddr,
  output logic                   m_clast,
  output logic                   m_cread,
  output logic                   m_cwrite,
  output logic [DATA_BITS/8-1:0] m_cstrb,
  output logic [DATA_BITS-1:0]   m_cdata,
  input  logic                   m_cready,

  input  logic [ID_BITS-1:0]     m_rid,
  input  logic [DATA_BITS-1:0]   m_rdata,
  input  logic                   m_rlast,
  input  logic                   m_rvalid,
  output logic                   m_rready,

  output logic [DATA_BITS-1:0]   m_tdata,
  output logic [ID_BITS-1:0]     m_tuser,
  output logic                   m_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready
`ifdef JELLY3_BRAM_BURST_READER_CHECK_EN
  ,
  output logic                   err
`endif
);

  localparam int CREDIT_BITS = credit_bits(FIFO_DEPTH);
  localparam int FIFO_WIDTH  = DATA_BITS + ID_BITS + 1;

  state_t                 state;
  logic [LEN_BITS-1:0]    remaining;
  logic [CREDIT_BITS-1:0] credit;
  logic [CREDIT_BITS-1:0] credit_next;

  logic cmd_xfer;
  logic pop;
  logic push;
  logic push_last;

  logic [FIFO_WIDTH-1:0] fifo_out;

  assign m_cwrite = 1'b0;
  assign m_cstrb  = '0;
  assign m_cdata  = '0;

  always_comb begin
    cmd_xfer    = m_cread && m_cready;
    pop         = m_tvalid && m_tready;
    push        = m_rvalid && m_rready;
    push_last   = push && m_rlast;
    credit_next = credit;
    case ({cmd_xfer, pop})
      2'b10:   credit_next = credit - CREDIT_BITS'(1);
      2'b01:   credit_next = credit + CREDIT_BITS'(1);
      default: credit_next = credit;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      m_cread   <= 1'b0;
      m_caddr   <= '0;
      m_cid     <= '0;
      m_clast   <= 1'b0;
      remaining <= '0;
      credit    <= CREDIT_BITS'(FIFO_DEPTH);
      m_rready  <= 1'b0;
    end else begin
      m_rready <= 1'b1;
      credit   <= credit_next;
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            s_ready   <= 1'b0;
            m_caddr   <= s_addr;
            m_cid     <= s_id;
            remaining <= s_len;
            m_clast   <= (s_len == '0);
            m_cread   <= (credit_next != '0);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_xfer) begin
            m_caddr <= m_caddr + ADDR_BITS'(1);
            if (m_clast) begin
              m_cread <= 1'b0;
              m_clast <= 1'b0;
              // A zero-latency slave may return the last beat in the same cycle.
              state   <= push_last ? IDLE : DRAIN;
              s_ready <= push_last;
            end else begin
              remaining <= remaining - LEN_BITS'(1);
              m_clast   <= (remaining == LEN_BITS'(1));
              m_cread   <= (credit_next != '0);
            end
          end else begin
            m_cread <= (credit_next != '0);
          end
        end
        DRAIN: begin
          if (push_last) begin
            state   <= IDLE;
            s_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  jelly3_bram_burst_reader_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .s_data  ({m_rlast, m_rid, m_rdata}),
    .s_valid (push),
    .m_data  (fifo_out),
    .m_valid (m_tvalid),
    .m_ready (m_tready)
  );

  assign {m_tlast, m_tuser, m_tdata} = fifo_out;

`ifdef JELLY3_BRAM_BURST_READER_CHECK_EN
  logic [LEN_BITS-1:0] rx_remaining;

  // m_cid stays at the latched burst ID until the next request is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_remaining <= '0;
      err          <= 1'b0;
    end else if (state == IDLE && s_valid && s_ready) begin
      rx_remaining <= s_len;
    end else if (push) begin
      if ((m_rid != m_cid) || (m_rlast != (rx_remaining == '0))) begin
        err <= 1'b1;
      end
      rx_remaining <= rx_remaining - LEN_BITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_jelly3_bram_burst_reader.sv
// Bench for jelly3_bram_burst_reader: BRAM slave model plus a stream-level
// reference model, directed scenarios followed by randomized bursts.
module tb_jelly3_bram_burst_reader;

  localparam int ADDR_BITS  = 10;
  localparam int DATA_BITS  = 32;
  localparam int ID_BITS    = 4;
  localparam int LEN_BITS   = 8;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset_n;
  logic [ADDR_BITS-1:0]   s_addr;
  logic [LEN_BITS-1:0]    s_len;
  logic [ID_BITS-1:0]     s_id;
  logic                   s_valid;
  logic                   s_ready;
  logic [ID_BITS-1:0]     m_cid;
  logic [ADDR_BITS-1:0]   m_caddr;
  logic                   m_clast;
  logic                   m_cread;
  logic                   m_cwrite;
  logic [DATA_BITS/8-1:0] m_cstrb;
  logic [DATA_BITS-1:0]   m_cdata;
  logic                   m_cready;
  logic [ID_BITS-1:0]     m_rid;
  logic [DATA_BITS-1:0]   m_rdata;
  logic                   m_rlast;
  logic                   m_rvalid;
  logic                   m_rready;
  logic [DATA_BITS-1:0]   m_tdata;
  logic [ID_BITS-1:0]     m_tuser;
  logic                   m_tlast;
  logic                   m_tvalid;
  logic                   m_tready;
`ifdef JELLY3_BRAM_BURST_READER_CHECK_EN
  logic                   err;
`endif

  jelly3_bram_burst_reader #(
    .ADDR_BITS  (ADDR_BITS),
    .DATA_BITS  (DATA_BITS),
    .ID_BITS    (ID_BITS),
    .LEN_BITS   (LEN_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_addr   (s_addr),
    .s_len    (s_len),
    .s_id     (s_id),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_cid    (m_cid),
    .m_caddr  (m_caddr),
    .m_clast  (m_clast),
    .m_cread  (m_cread),
    .m_cwrite (m_cwrite),
    .m_cstrb  (m_cstrb),
    .m_cdata  (m_cdata),
    .m_cready (m_cready),
    .m_rid    (m_rid),
    .m_rdata  (m_rdata),
    .m_rlast  (m_rlast),
    .m_rvalid (m_rvalid),
    .m_rready (m_rready),
    .m_tdata  (m_tdata),
    .m_tuser  (m_tuser),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready)
`ifdef JELLY3_BRAM_BURST_READER_CHECK_EN
    ,
    .err      (err)
`endif
  );

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [ID_BITS-1:0]   id;
    logic                 last;
  } cmd_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [ID_BITS-1:0]   id;
    logic                 last;
  } beat_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [LEN_BITS-1:0]  len;
    logic [ID_BITS-1:0]   id;
  } req_t;

  typedef struct {
    cmd_t        c;
    int unsigned due;
  } pend_t;

  req_t  req_q[$];
  cmd_t  exp_cmd[$];
  beat_t exp_beat[$];
  pend_t slave_q[$];
  logic [ADDR_BITS-1:0] cmd_log[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  bit          busy;
  int unsigned issued, popped, rxd, cyc;
  int unsigned beat_count, tlast_count, clast_count;
  int          cready_mode, tready_mode;
  int unsigned lat_max;

  bit    sv_acc, sv_cmd, sv_resp, sv_rlast, sv_pop;
  cmd_t  sv_c;
  beat_t sv_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_BITS-1:0] mem_word(input logic [ADDR_BITS-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Driver, slave and per-cycle comparison against the stream model.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        req_q.delete();
        exp_cmd.delete();
        exp_beat.delete();
        slave_q.delete();
        busy = 0; issued = 0; popped = 0; rxd = 0;
        sv_acc = 0; sv_cmd = 0; sv_resp = 0; sv_rlast = 0; sv_pop = 0;
        s_valid = 0; m_cready = 0; m_rvalid = 0; m_tready = 0;
        m_rid = '0; m_rdata = '0; m_rlast = 0;
      end else begin
        if (sv_acc) begin
          req_t r;
          r = req_q.pop_front();
          busy = 1;
          for (int k = 0; k <= int'(r.len); k++) begin
            logic [ADDR_BITS-1:0] a;
            a = r.addr + ADDR_BITS'(k);
            exp_cmd.push_back('{addr: a, id: r.id, last: (k == int'(r.len))});
            exp_beat.push_back('{data: mem_word(a), id: r.id, last: (k == int'(r.len))});
          end
        end
        if (sv_cmd) begin
          pend_t p;
          p.c   = sv_c;
          p.due = cyc + ((lat_max != 0) ? $urandom_range(0, lat_max) : 0);
          slave_q.push_back(p);
          issued++;
          cmd_log.push_back(sv_c.addr);
          if (sv_c.last) clast_count++;
          if (exp_cmd.size() != 0) void'(exp_cmd.pop_front());
        end
        if (sv_resp) begin
          if (slave_q.size() != 0) void'(slave_q.pop_front());
          rxd++;
          if (sv_rlast) busy = 0;
        end
        if (sv_pop) begin
          popped++;
          beat_count++;
          if (sv_beat.last) tlast_count++;
          if (exp_beat.size() == 0) check("stream_extra_beat", sv_beat, '0);
          else check("stream_beat", sv_beat, exp_beat.pop_front());
        end

        check("s_ready", s_ready, !busy);
        check("m_rready", m_rready, 1'b1);
        check("m_tvalid", m_tvalid, rxd != popped);
        check("m_cread", m_cread, (exp_cmd.size() != 0) && ((issued - popped) < FIFO_DEPTH));
        if (m_cread && exp_cmd.size() != 0)
          check("cmd_fields", {m_caddr, m_cid, m_clast}, exp_cmd[0]);
        check("tied_write", {m_cwrite, m_cstrb, m_cdata}, '0);

        s_valid = (req_q.size() != 0);
        if (req_q.size() != 0) begin
          s_addr = req_q[0].addr;
          s_len  = req_q[0].len;
          s_id   = req_q[0].id;
        end
        m_cready = (cready_mode == 1) ? 1'b0 : (cready_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
        m_tready = (tready_mode == 1) ? 1'b0 : (tready_mode == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (slave_q.size() != 0 && slave_q[0].due <= cyc) begin
          m_rvalid = 1;
          m_rid    = slave_q[0].c.id;
          m_rdata  = mem_word(slave_q[0].c.addr);
          m_rlast  = slave_q[0].c.last;
        end else begin
          m_rvalid = 0;
          m_rid    = '0;
          m_rdata  = '0;
          m_rlast  = 0;
        end

        sv_acc   = s_valid && s_ready;
        sv_cmd   = m_cread && m_cready;
        sv_c     = '{addr: m_caddr, id: m_cid, last: m_clast};
        sv_resp  = m_rvalid && m_rready;
        sv_rlast = m_rlast;
        sv_pop   = m_tvalid && m_tready;
        sv_beat  = '{data: m_tdata, id: m_tuser, last: m_tlast};
      end
    end
  end

  task automatic wait_idle(input int unsigned budget, input string name);
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (!busy && req_q.size() == 0 && exp_beat.size() == 0) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout after %0d cycles, beats pending %0d", name, budget, exp_beat.size());
  endtask

  task automatic wait_cmds(input int unsigned n, input int unsigned budget, input string name);
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (cmd_log.size() >= n) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout, commands seen %0d required %0d", name, cmd_log.size(), n);
  endtask

  task automatic start_test();
    cmd_log.delete();
    beat_count  = 0;
    tlast_count = 0;
    clast_count = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_outs"}, {s_ready, m_cread, m_tvalid, m_caddr, m_cid, m_clast, m_rready}, '0);
  endtask

  initial begin
    logic [ADDR_BITS-1:0] t1_addr [4];
    logic [ADDR_BITS-1:0] t3_addr [4];
    logic [ADDR_BITS-1:0] held;
    int unsigned          total;

    t1_addr = '{10'h010, 10'h011, 10'h012, 10'h013};
    t3_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

    reset_n = 0; s_valid = 0; s_addr = '0; s_len = '0; s_id = '0;
    m_cready = 0; m_tready = 0; m_rvalid = 0; m_rid = '0; m_rdata = '0; m_rlast = 0;
    cready_mode = 2; tready_mode = 2; lat_max = 0;

    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    reset_n = 1;

    // 4-beat burst, 1-cycle slave
    start_test();
    req_q.push_back('{addr: 10'h010, len: 8'd3, id: 4'd5});
    wait_idle(200, "t1_wait");
    check("t1_ncmd", cmd_log.size(), 4);
    for (int i = 0; i < 4; i++) if (i < cmd_log.size()) check("t1_caddr", cmd_log[i], t1_addr[i]);
    check("t1_clast", clast_count, 1);
    check("t1_beats", beat_count, 4);
    check("t1_tlast", tlast_count, 1);

    // stream stalled: credit caps outstanding reads
    start_test();
    tready_mode = 1;
    req_q.push_back('{addr: 10'h100, len: 8'd7, id: 4'd9});
    repeat (30) @(negedge clk);
    #2;
    check("t2_ncmd_stalled", cmd_log.size(), 4);
    check("t2_cread_stalled", m_cread, 1'b0);
    tready_mode = 2;
    wait_idle(300, "t2_wait");
    check("t2_ncmd", cmd_log.size(), 8);
    check("t2_beats", beat_count, 8);
    check("t2_tlast", tlast_count, 1);

    // address wrap
    start_test();
    req_q.push_back('{addr: 10'h3FE, len: 8'd3, id: 4'd2});
    wait_idle(200, "t3_wait");
    check("t3_ncmd", cmd_log.size(), 4);
    for (int i = 0; i < 4; i++) if (i < cmd_log.size()) check("t3_caddr", cmd_log[i], t3_addr[i]);

    // m_cready held low mid-burst
    start_test();
    req_q.push_back('{addr: 10'h200, len: 8'd9, id: 4'd3});
    wait_cmds(3, 100, "t4_start");
    cready_mode = 1;
    @(negedge clk); #2;
    held = m_caddr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      check("t4_hold_cread", m_cread, 1'b1);
      check("t4_hold_caddr", m_caddr, held);
    end
    cready_mode = 2;
    wait_idle(300, "t4_wait");
    check("t4_ncmd", cmd_log.size(), 10);
    check("t4_beats", beat_count, 10);

    // single-beat burst
    start_test();
    req_q.push_back('{addr: 10'h055, len: 8'd0, id: 4'd7});
    wait_idle(200, "t5_wait");
    check("t5_ncmd", cmd_log.size(), 1);
    check("t5_clast", clast_count, 1);
    check("t5_beats", beat_count, 1);
    check("t5_tlast", tlast_count, 1);

    // reset during ISSUE, then a clean burst
    start_test();
    tready_mode = 1;
    req_q.push_back('{addr: 10'h0A0, len: 8'd15, id: 4'd4});
    wait_cmds(2, 100, "t6_start");
    @(negedge clk); #2;
    reset_n = 0;
    #1;
    check_reset_outputs("t6_midreset");
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1;
    tready_mode = 2;
    start_test();
    req_q.push_back('{addr: 10'h0C0, len: 8'd2, id: 4'd6});
    wait_idle(200, "t6_wait");
    check("t6_beats", beat_count, 3);
    check("t6_tlast", tlast_count, 1);
`ifdef JELLY3_BRAM_BURST_READER_CHECK_EN
    check("t6_err", err, 1'b0);
`endif

    // randomized bursts with random back-pressure and slave latency
    start_test();
    cready_mode = 0;
    tready_mode = 0;
    lat_max     = 2;
    total       = 0;
    for (int i = 0; i < 25; i++) begin
      req_t r;
      r.addr = ADDR_BITS'($urandom);
      r.len  = LEN_BITS'($urandom_range(0, 12));
      r.id   = ID_BITS'($urandom);
      total += int'(r.len) + 1;
      req_q.push_back(r);
    end
    wait_idle(5000, "rand_wait");
    check("rand_beats", beat_count, total);
    check("rand_tlast", tlast_count, 25);
`ifdef JELLY3_BRAM_BURST_READER_CHECK_EN
    check("rand_err", err, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
